// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared FSM encodings, default timing constants and tick source indices.
package stopwatch_pkg;
  localparam logic [1:0] ST_RUN = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;
  localparam int GUARD_CYC_DEF = 4;
  localparam int TIMEOUT_DEF = 1023;
  localparam int SRC_NORM = 0;
  localparam int SRC_ADJ = 1;
  localparam int SRC_BLINK = 2;
endpackage

// File: rtl/tick_selector_if.sv
// tick_selector_if: tick sources, select/pause requests and selector status.
interface tick_selector_if #(parameter int N_SRC = 2);
  localparam int SEL_W = $clog2(N_SRC);
  logic [N_SRC-1:0] tick_in;
  logic [SEL_W-1:0] sel;
  logic pause;
  logic tick_out;
  logic [SEL_W-1:0] cur_sel;
  logic switching;
  logic dropped;
  modport master(output tick_in, sel, pause, input tick_out, cur_sel, switching, dropped);
  modport slave(input tick_in, sel, pause, output tick_out, cur_sel, switching, dropped);
endinterface

// File: rtl/tick_guard_counter.sv
// tick_guard_counter: saturating up-counter with clear and terminal-count compare against a runtime limit.
module tick_guard_counter #(parameter int CNT_W = 10) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = clr ? '0 : (en && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    tc = cnt_q == limit;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/tick_selector.sv
// tick_selector: glitch-free N-way tick-enable mux with guard window and dead-source timeout.
module tick_selector
  import stopwatch_pkg::*;
#(
  parameter int N_SRC = 2,
  parameter int GUARD_CYC = GUARD_CYC_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W = 10,
  localparam int SEL_W = $clog2(N_SRC)
) (
  input logic clk,
  input logic rst_n,
  tick_selector_if.slave bus
);
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GD_LIM = CNT_W'(GUARD_CYC - 1);
  logic [1:0] state_q, state_d;
  logic [SEL_W-1:0] cur_sel_q, cur_sel_d, target_q, target_d, tgt;
  logic held_q, held_d, tick_out_q, tick_out_d, dropped_q, dropped_d, switching_q, switching_d;
  logic live, tk, sel_ok, tc;
  always_comb begin
    live = bus.tick_in[cur_sel_q];
    tk = live & ~bus.pause;
    sel_ok = 32'(bus.sel) < N_SRC;
    tgt = sel_ok ? bus.sel : target_q;
    state_d = state_q;
    cur_sel_d = cur_sel_q;
    target_d = target_q;
    held_d = held_q;
    tick_out_d = 1'b0;
    dropped_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        tick_out_d = (live | held_q) & ~bus.pause;
        held_d = 1'b0;
        if (sel_ok && bus.sel != cur_sel_q) begin
          target_d = bus.sel;
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        tick_out_d = tk;
        target_d = tgt;
        if (tgt == cur_sel_q) state_d = ST_RUN;
        else if (live || tc) begin
          cur_sel_d = tgt;
          state_d = ST_GUARD;
        end
      end
      default: begin
        // first new-source tick is held for release in RUN; any later one is discarded
        held_d = held_q | tk;
        dropped_d = held_q & tk;
        if (tc) state_d = ST_RUN;
      end
    endcase
    switching_d = state_d != ST_RUN;
  end
  tick_guard_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_d != state_q),
    .en   (state_q != ST_RUN),
    .limit(state_q == ST_PEND ? TO_LIM : GD_LIM),
    .tc   (tc)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_RUN;
      cur_sel_q <= SEL_W'(SRC_NORM);
      target_q <= SEL_W'(SRC_NORM);
      held_q <= 1'b0;
      tick_out_q <= 1'b0;
      dropped_q <= 1'b0;
      switching_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_sel_q <= cur_sel_d;
      target_q <= target_d;
      held_q <= held_d;
      tick_out_q <= tick_out_d;
      dropped_q <= dropped_d;
      switching_q <= switching_d;
    end
  assign bus.tick_out = tick_out_q;
  assign bus.cur_sel = cur_sel_q;
  assign bus.switching = switching_q;
  assign bus.dropped = dropped_q;
endmodule

// File: tb/tb_tick_selector.sv
// tb_tick_selector: directed stimulus with a timestamp-based reference model checked every cycle.
module tb_tick_selector;
  import stopwatch_pkg::*;
  localparam int N = 3, G = 4, T = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  tick_selector_if #(.N_SRC(N)) bus ();
  tick_selector #(.N_SRC(N), .GUARD_CYC(G), .TIMEOUT(T), .CNT_W(10)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );
  int checks = 0, fails = 0;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d at %0t", nm, got, exp, $time);
    end
  endtask
  // Model: switch phases tracked by the cycle they started, not by a counter register.
  int cyc = 0, p0 = 0, g0 = 0, m_cur = 0, m_tgt = 0, s = 0;
  bit m_pend = 0, m_guard = 0, m_held = 0, live = 0, valid = 0;
  logic e_tick = 1'b0, e_drop = 1'b0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_pend = 0; m_guard = 0; m_held = 0; m_cur = 0; m_tgt = 0;
      e_tick = 1'b0; e_drop = 1'b0;
    end else begin
      s = int'(bus.sel);
      valid = s < N;
      live = bus.tick_in[m_cur];
      e_tick = 1'b0;
      e_drop = 1'b0;
      if (m_guard) begin
        if (live && !bus.pause) begin
          if (m_held) e_drop = 1'b1;
          else m_held = 1;
        end
        if (cyc - g0 == G - 1) m_guard = 0;
      end else if (m_pend) begin
        if (valid) m_tgt = s;
        e_tick = live && !bus.pause;
        if (m_tgt == m_cur) m_pend = 0;
        else if (live || cyc - p0 == T - 1) begin
          m_cur = m_tgt; m_pend = 0; m_guard = 1; g0 = cyc + 1;
        end
      end else begin
        e_tick = (live || m_held) && !bus.pause;
        m_held = 0;
        if (valid && s != m_cur) begin
          m_tgt = s; m_pend = 1; p0 = cyc + 1;
        end
      end
      cyc++;
    end
  always @(negedge clk) begin
    chk("m_tick_out", bus.tick_out, e_tick);
    chk("m_cur_sel", bus.cur_sel, m_cur);
    chk("m_switching", bus.switching, m_pend | m_guard);
    chk("m_dropped", bus.dropped, e_drop);
  end
  task automatic step(input logic [2:0] ti, input logic [1:0] sl, input logic p);
    bus.tick_in = ti;
    bus.sel = sl;
    bus.pause = p;
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.tick_in = '0; bus.sel = '0; bus.pause = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tick", bus.tick_out, 0);
    chk("rst_cur", bus.cur_sel, 0);
    chk("rst_sw", bus.switching, 0);
    chk("rst_drop", bus.dropped, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(3'b001, 0, 0); chk("pt_tick", bus.tick_out, 1); chk("pt_cur", bus.cur_sel, 0);
      step(3'b010, 0, 0); chk("pt_ignore", bus.tick_out, 0); chk("pt_sw", bus.switching, 0);
      repeat (6) step(3'b000, 0, 0);
    end
    step(3'b000, 1, 0); chk("cs_sw_on", bus.switching, 1); chk("cs_cur_old", bus.cur_sel, 0);
    repeat (4) step(3'b000, 1, 0);
    step(3'b001, 1, 0); chk("cs_old_tick", bus.tick_out, 1); chk("cs_cur_new", bus.cur_sel, 1);
    step(3'b010, 1, 0); chk("cs_guard_mute", bus.tick_out, 0); chk("cs_no_drop", bus.dropped, 0);
    step(3'b010, 1, 0); chk("cs_drop", bus.dropped, 1);
    step(3'b000, 1, 0); chk("cs_drop_clr", bus.dropped, 0); chk("cs_sw_guard", bus.switching, 1);
    step(3'b000, 1, 0); chk("cs_sw_off", bus.switching, 0);
    step(3'b000, 1, 0); chk("cs_held_out", bus.tick_out, 1);
    step(3'b000, 1, 0); chk("cs_single", bus.tick_out, 0);
    repeat (16) step(3'b000, SRC_NORM, 0);
    chk("to_cur_wait", bus.cur_sel, 1); chk("to_sw_wait", bus.switching, 1);
    step(3'b000, SRC_NORM, 0); chk("to_cur_forced", bus.cur_sel, 0); chk("to_no_tick", bus.tick_out, 0);
    repeat (3) step(3'b000, SRC_NORM, 0);
    chk("to_guard", bus.switching, 1);
    step(3'b000, SRC_NORM, 0); chk("to_run", bus.switching, 0);
    step(3'b000, SRC_BLINK, 0); chk("can_pend", bus.switching, 1);
    step(3'b001, SRC_NORM, 0); chk("can_tick", bus.tick_out, 1); chk("can_sw", bus.switching, 0);
    chk("can_cur", bus.cur_sel, 0);
    step(3'b000, 3, 0); chk("oor_sw", bus.switching, 0);
    step(3'b001, 3, 0); chk("oor_tick", bus.tick_out, 1); chk("oor_cur", bus.cur_sel, 0);
    step(3'b000, SRC_BLINK, 0);
    step(3'b000, SRC_ADJ, 0);
    step(3'b001, 3, 0); chk("rt_cur", bus.cur_sel, SRC_ADJ); chk("rt_tick", bus.tick_out, 1);
    repeat (4) step(3'b000, SRC_ADJ, 0);
    chk("rt_run", bus.switching, 0);
    step(3'b010, SRC_ADJ, 1); chk("pz_tick1", bus.tick_out, 0);
    step(3'b000, SRC_ADJ, 1);
    step(3'b010, SRC_ADJ, 1); chk("pz_tick2", bus.tick_out, 0); chk("pz_drop", bus.dropped, 0);
    step(3'b000, SRC_NORM, 1); chk("pz_pend", bus.switching, 1);
    step(3'b010, SRC_NORM, 1); chk("pz_sw_tick", bus.tick_out, 0); chk("pz_sw_cur", bus.cur_sel, 0);
    repeat (4) step(3'b000, SRC_NORM, 1);
    chk("pz_run", bus.switching, 0);
    step(3'b001, SRC_NORM, 0); chk("pz_resume", bus.tick_out, 1);
    step(3'b000, SRC_BLINK, 0);
    step(3'b001, SRC_BLINK, 0); chk("ar_cur", bus.cur_sel, SRC_BLINK);
    step(3'b100, SRC_BLINK, 0);
    bus.tick_in = '0; bus.sel = SRC_NORM;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_tick", bus.tick_out, 0); chk("ar_cur0", bus.cur_sel, 0);
    chk("ar_sw", bus.switching, 0); chk("ar_drop", bus.dropped, 0);
    @(negedge clk) rst_n = 1'b1;
    step(3'b001, SRC_NORM, 0); chk("ar_first", bus.tick_out, 1);
    step(3'b000, SRC_NORM, 0); chk("ar_held_gone", bus.tick_out, 0);
    repeat (3) step(3'b000, SRC_NORM, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
